cordic_result_display: RTL

//  Consumer stage for the CORDIC processor's 32-bit result bus on the DE-board top level.

---
 rtl/cordic_result_display.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cordic_result_display.sv
// cordic_result_display: latches the CORDIC result when Done rises and pages it
// across six active-low 7-segment digits (low 24 bits / high 8 bits). The page
// is flipped by a debounced push-button, with an optional periodic auto-page.

// One display digit: registered hex-to-7-segment decode with a dash for blank.
module cordic_hex_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       blank_i,
  input  logic [3:0] nib_i,
  output logic [6:0] hex_o
);
  localparam logic [6:0] DASH = 7'h3F;

  // Active-low {g,f,e,d,c,b,a} patterns for 0..F.
  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
  endfunction

  // Register the decoded segment pattern; dashes until something is captured.
  always_ff @(posedge clk) begin
    if (rst || blank_i) hex_o <= DASH;
    else                hex_o <= seg(nib_i);
  end
endmodule

module cordic_result_display #(
  parameter int DB_CYCLES   = 500_000,
  parameter int AUTO_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done_i,
  input  logic [31:0] data_i,
  input  logic        page_btn_n,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        captured,
  output logic        page
);
  localparam int NUM_DIGITS = 6;
  localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int AW  = (AUTO_CYCLES > 2) ? $clog2(AUTO_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [AW-1:0]  AUTO_LAST = AW'((AUTO_CYCLES > 0) ? AUTO_CYCLES - 1 : 0);
  localparam bit AUTO_EN = (AUTO_CYCLES > 0);

  // Button synchroniser and debouncer state.
  logic           btn_s1_q, btn_s2_q;
  logic           db_state_q;             // debounced level, 1 = released
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           db_state_d;
  logic           press_evt;

  // Capture and page state.
  logic           done_q;
  logic           rise;
  logic [31:0]    result_q;
  logic           captured_q;
  logic           page_q, page_d;
  logic [AW-1:0]  auto_q, auto_d;

  logic [NUM_DIGITS-1:0][6:0] hex_q;
  logic [NUM_DIGITS-1:0][3:0] nib;

  // Two-flop synchroniser; idle level of the active-low key is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q <= 1'b1;
      btn_s2_q <= 1'b1;
    end else begin
      btn_s1_q <= page_btn_n;
      btn_s2_q <= btn_s1_q;
    end
  end

  // Debounce: count consecutive cycles the synced level disagrees with the
  // accepted level; accept it after DB_CYCLES of disagreement.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_state_d = db_state_q;
    press_evt  = 1'b0;
    if (btn_s2_q == db_state_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d   = '0;
      db_state_d = btn_s2_q;
      press_evt  = ~btn_s2_q;             // only the released->pressed flip
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q   <= '0;
      db_state_q <= 1'b1;
    end else begin
      db_cnt_q   <= db_cnt_d;
      db_state_q <= db_state_d;
    end
  end

  assign rise = done_i & ~done_q;

  // Page priority: a capture forces page 0 and swallows a coincident press;
  // a press toggles and restarts the auto period; otherwise auto-page runs.
  always_comb begin
    page_d = page_q;
    auto_d = auto_q;
    if (rise) begin
      page_d = 1'b0;
      auto_d = '0;
    end else if (press_evt) begin
      page_d = ~page_q;
      auto_d = '0;
    end else if (AUTO_EN && captured_q) begin
      if (auto_q == AUTO_LAST) begin
        page_d = ~page_q;
        auto_d = '0;
      end else begin
        auto_d = auto_q + 1'b1;
      end
    end
  end

  // Capture on the Done rising edge and hold until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q     <= 1'b0;
      result_q   <= '0;
      captured_q <= 1'b0;
      page_q     <= 1'b0;
      auto_q     <= '0;
    end else begin
      done_q <= done_i;
      page_q <= page_d;
      auto_q <= auto_d;
      if (rise) begin
        result_q   <= data_i;
        captured_q <= 1'b1;
      end
    end
  end

  // Per-digit nibble select: page 0 shows result[23:0], page 1 shows
  // result[31:24] on the two rightmost digits and zeros elsewhere.
  for (genvar n = 0; n < NUM_DIGITS; n++) begin : g_dig
    if (n < 2) begin : g_hi
      assign nib[n] = page_q ? result_q[24 + 4*n +: 4] : result_q[4*n +: 4];
    end else begin : g_lo
      assign nib[n] = page_q ? 4'h0 : result_q[4*n +: 4];
    end

    cordic_hex_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .blank_i (~captured_q),
      .nib_i   (nib[n]),
      .hex_o   (hex_q[n])
    );
  end

  assign hex0     = hex_q[0];
  assign hex1     = hex_q[1];
  assign hex2     = hex_q[2];
  assign hex3     = hex_q[3];
  assign hex4     = hex_q[4];
  assign hex5     = hex_q[5];
  assign captured = captured_q;
  assign page     = page_q;
endmodule
